tone_note_decoder: RTL and testbench

- Inverse of the lullaby piezo path: takes a square-wave tone (microphone comparator or looped-back piezo pin) and recovers the 13-bit one-hot note code that drives the piezo tone generator.
- Measures input period, classifies it against the 13-note chromatic table C4..C5, and reports a stable note, a valid flag and a change pulse.
- Feeds the sleep/monitor logic, and provides loopback self-test of the piezo generator.

---
 rtl/tone_note_decoder_pkg.sv | 51 +++++
 rtl/tone_note_decoder_if.sv | 20 ++
 rtl/tone_period_meter.sv | 52 +++++
 rtl/tone_note_decoder.sv | 104 ++++++++++
 tb/tb_tone_note_decoder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_note_decoder_pkg.sv
// Shared note definitions for the piezo tone path: note table, one-hot indices and the
// period-to-note window classifier.
package tone_note_decoder_pkg;

    localparam int unsigned NOTE_NUM = 13;
    localparam int unsigned PERIOD_W = 19;

    typedef logic [NOTE_NUM-1:0] note_t;
    typedef logic [PERIOD_W-1:0] period_t;
    typedef period_t note_table_t [NOTE_NUM];

    // Tone periods in 50 MHz clock cycles, C4 first.
    localparam note_table_t NOTE_PERIOD = '{
        19'd191110, 19'd180388, 19'd170265, 19'd160704, 19'd151686, 19'd143172, 19'd135139,
        19'd127551, 19'd120395, 19'd113636, 19'd107260, 19'd101239, 19'd95557
    };

    localparam int unsigned NOTE_C4  = 0;
    localparam int unsigned NOTE_CS4 = 1;
    localparam int unsigned NOTE_D4  = 2;
    localparam int unsigned NOTE_DS4 = 3;
    localparam int unsigned NOTE_E4  = 4;
    localparam int unsigned NOTE_F4  = 5;
    localparam int unsigned NOTE_FS4 = 6;
    localparam int unsigned NOTE_G4  = 7;
    localparam int unsigned NOTE_GS4 = 8;
    localparam int unsigned NOTE_A4  = 9;
    localparam int unsigned NOTE_AS4 = 10;
    localparam int unsigned NOTE_B4  = 11;
    localparam int unsigned NOTE_C5  = 12;

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    // Windows are narrower than half the note spacing, so at most one bit is ever set.
    function automatic note_t classify(input period_t p, input note_table_t tbl,
                                       input int unsigned tol_shift);
        note_t                    m;
        logic signed [PERIOD_W:0] diff;
        logic [PERIOD_W:0]        mag;
        period_t                  win;
        m = '0;
        for (int unsigned k = 0; k < NOTE_NUM; k++) begin
            diff = $signed({1'b0, p}) - $signed({1'b0, tbl[k]});
            mag  = diff[PERIOD_W] ? unsigned'(-diff) : unsigned'(diff);
            win  = tbl[k] >> tol_shift;
            m[k] = (mag <= {1'b0, win});
        end
        return m;
    endfunction

endpackage

// File: rtl/tone_note_decoder_if.sv
// Tone input and decoded-note outputs of the tone note decoder.
interface tone_note_decoder_if;

    logic                          tone_in;
    tone_note_decoder_pkg::note_t   note;
    logic                          note_valid;
    logic                          note_change;
    tone_note_decoder_pkg::period_t period;

    modport master (
        output tone_in,
        input  note, note_valid, note_change, period
    );

    modport slave (
        input  tone_in,
        output note, note_valid, note_change, period
    );

endinterface

// File: rtl/tone_period_meter.sv
// Synchronises the tone pin, deglitches rising edges and measures the distance between
// accepted edges; flags a timeout when the tone has been absent too long.
module tone_period_meter
    import tone_note_decoder_pkg::*;
#(
    parameter int unsigned MIN_PERIOD  = 1000,
    parameter int unsigned TIMEOUT_CYC = 250000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    tone_in,
    input  logic    idle,
    output logic    acc_edge,
    output logic    cap,
    output logic    timeout,
    output period_t period
);

    logic    s1, s2, s3;
    logic    rise;
    period_t cnt;

    assign rise     = s2 & ~s3;
    // In idle any edge restarts measurement; otherwise short gaps are treated as glitches.
    assign acc_edge = rise & (idle | (cnt >= PERIOD_W'(MIN_PERIOD)));
    assign timeout  = ~idle & ~acc_edge & (cnt == PERIOD_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            cnt    <= '0;
            cap    <= 1'b0;
            period <= '0;
        end else begin
            s1  <= tone_in;
            s2  <= s1;
            s3  <= s2;
            cap <= acc_edge & ~idle;
            if (acc_edge) begin
                cnt <= period_t'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + period_t'(1);
            end
            if (acc_edge && !idle) begin
                period <= cnt;
            end
        end
    end

endmodule

// File: rtl/tone_note_decoder.sv
// Recovers the one-hot note code from a square-wave tone: measures the period, classifies
// it against the note table and reports a note once it has been stable for a few periods.
module tone_note_decoder
    import tone_note_decoder_pkg::*;
#(
    parameter int unsigned TOL_SHIFT   = 6,
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned MIN_PERIOD  = 1000,
    parameter int unsigned TIMEOUT_CYC = 250000,
    parameter note_table_t NOTE_TABLE  = NOTE_PERIOD
) (
    input logic               clk,
    input logic               rst,
    tone_note_decoder_if.slave bus
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    state_e     state_q, state_d;
    note_t      note_q, note_d;
    note_t      cand_q, cand_d;
    logic [3:0] run_q, run_d;
    logic       valid_q, valid_d;
    logic       change_q, change_d;
    logic       acc_edge, cap, timeout;
    period_t    period;
    note_t      match;

    tone_period_meter #(
        .MIN_PERIOD (MIN_PERIOD),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_meter (
        .clk     (clk),
        .rst     (rst),
        .tone_in (bus.tone_in),
        .idle    (state_q == StIdle),
        .acc_edge(acc_edge),
        .cap     (cap),
        .timeout (timeout),
        .period  (period)
    );

    assign match = classify(period, NOTE_TABLE, TOL_SHIFT);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        cand_d  = cand_q;
        run_d   = run_q;
        valid_d = valid_q;
        if (timeout) begin
            state_d = StIdle;
            note_d  = '0;
            valid_d = 1'b0;
            cand_d  = '0;
            run_d   = '0;
        end else begin
            if (acc_edge && state_q == StIdle) begin
                state_d = StMeasure;
            end
            if (cap) begin
                if (match != '0 && match == cand_q) begin
                    if (run_q < STABLE) begin
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    cand_d = match;
                    run_d  = (match != '0) ? 4'd1 : 4'd0;
                end
                // An outlier only resets the run; the reported note is held.
                if (run_d == STABLE && cand_d != note_q) begin
                    note_d  = cand_d;
                    valid_d = 1'b1;
                    state_d = StLocked;
                end
            end
        end
        change_d = (note_d != note_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            note_q   <= '0;
            cand_q   <= '0;
            run_q    <= '0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
            change_q <= change_d;
        end
    end

    assign bus.note        = note_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_change = change_q;
    assign bus.period      = period;

endmodule

// File: tb/tb_tone_note_decoder.sv
// Scoreboarded bench for tone_note_decoder using a note table scaled down by 128 so that
// whole tone periods fit in a short run; the full-size table is checked via classify().
module tb_tone_note_decoder;
    import tone_note_decoder_pkg::*;

    localparam int TOL  = 6;
    localparam int STB  = 4;
    localparam int MINP = 40;
    localparam int TMO  = 2000;
    localparam int SC [13] = '{1493, 1409, 1330, 1256, 1185, 1119, 1056, 996, 941, 888, 838,
                               791, 747};

    function automatic note_table_t scaled_table();
        note_table_t t;
        for (int k = 0; k < 13; k++) t[k] = period_t'(SC[k]);
        return t;
    endfunction

    localparam note_table_t DUT_TABLE = scaled_table();

    typedef struct {
        logic [12:0] note;
        logic        valid;
        longint      period;
        longint      t;
    } ev_t;

    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    int     n_chk = 0;
    int     n_err = 0;
    ev_t    sbq[$];

    // Reference model state, expressed in pin-edge times.
    bit     m_idle = 1'b1;
    longint m_last = 0;
    int     m_period = 0;
    int     m_cand = -1;
    int     m_run = 0;
    int     m_note = -1;

    tone_note_decoder_if bus ();

    tone_note_decoder #(
        .TOL_SHIFT  (TOL),
        .STABLE_CNT (STB),
        .MIN_PERIOD (MINP),
        .TIMEOUT_CYC(TMO),
        .NOTE_TABLE (DUT_TABLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int nearest(input int p);
        int d;
        for (int k = 0; k < 13; k++) begin
            d = p - SC[k];
            if (d < 0) d = -d;
            if (d <= (SC[k] >> TOL)) return k;
        end
        return -1;
    endfunction

    task automatic push_ev(input int idx, input longint t);
        ev_t e;
        e.note   = '0;
        if (idx >= 0) e.note[idx] = 1'b1;
        e.valid  = (idx >= 0);
        e.period = m_period;
        e.t      = t;
        sbq.push_back(e);
    endtask

    task automatic model_timeout_upto(input longint t_end);
        if (!m_idle && (t_end - m_last > TMO)) begin
            if (m_note >= 0) push_ev(-1, m_last + 3 + TMO);
            m_note = -1;
            m_cand = -1;
            m_run  = 0;
            m_idle = 1'b1;
        end
    endtask

    task automatic model_edge(input longint t);
        int gap;
        int k;
        model_timeout_upto(t);
        if (m_idle) begin
            m_idle = 1'b0;
            m_last = t;
            return;
        end
        gap = int'(t - m_last);
        if (gap < MINP) return;
        m_last   = t;
        m_period = gap;
        k = nearest(gap);
        if (k >= 0 && k == m_cand) begin
            if (m_run < STB) m_run++;
        end else begin
            m_cand = k;
            m_run  = (k >= 0) ? 1 : 0;
        end
        if (m_run == STB && m_cand != m_note) begin
            m_note = m_cand;
            push_ev(m_note, t + 4);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_period = 0;
        m_cand = -1;
        m_run  = 0;
        m_note = -1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One tone period; an optional short low dip shortly after the rising edge.
    task automatic play_period(input int p, input bit glitch);
        int o;
        int d;
        model_edge(cyc);
        bus.tone_in = 1'b1;
        if (glitch) begin
            o = $urandom_range(3, 20);
            d = $urandom_range(3, 10);
            step(o);
            bus.tone_in = 1'b0;
            step(d);
            model_edge(cyc);
            bus.tone_in = 1'b1;
            step(p / 2 - o - d);
        end else begin
            step(p / 2);
        end
        bus.tone_in = 1'b0;
        step(p - p / 2);
    endtask

    task automatic play(input int p, input int n, input bit glitch);
        for (int i = 0; i < n; i++) play_period(p, glitch);
    endtask

    task automatic silence(input int len);
        bus.tone_in = 1'b0;
        model_timeout_upto(cyc + len);
        step(len);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.note_change === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_change: note=0x%0h at cycle %0d, required no pulse",
                         bus.note, cyc);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                chk("chg_note", longint'(bus.note), longint'(e.note));
                chk("chg_valid", longint'(bus.note_valid), longint'(e.valid));
                chk("chg_period", longint'(bus.period), e.period);
                chk("chg_cycle", cyc, e.t);
            end
        end
    end

    initial begin
        int k;
        int tol;
        rst = 1'b0;
        bus.tone_in = 1'b0;
        step(3);
        chk("rst_note", longint'(bus.note), 0);
        chk("rst_valid", longint'(bus.note_valid), 0);
        chk("rst_change", longint'(bus.note_change), 0);
        chk("rst_period", longint'(bus.period), 0);
        rst = 1'b1;
        step(2);

        // Full-size table windows.
        chk("cls_a4_hi", longint'(classify(19'd115411, NOTE_PERIOD, 6)), 64'h0200);
        chk("cls_a4_lo", longint'(classify(19'd111861, NOTE_PERIOD, 6)), 64'h0200);
        chk("cls_a4_out", longint'(classify(19'd115412, NOTE_PERIOD, 6)), 0);
        chk("cls_116000", longint'(classify(19'd116000, NOTE_PERIOD, 6)), 0);
        chk("cls_c5", longint'(classify(19'd95557, NOTE_PERIOD, 6)), 64'h1000);
        chk("cls_c4", longint'(classify(19'd191110, NOTE_PERIOD, 6)), 64'h0001);
        chk("cls_sat", longint'(classify(19'h7ffff, NOTE_PERIOD, 6)), 0);

        // Lock A4, reset mid-lock, relock.
        play(SC[9], 6, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_note", longint'(bus.note), 0);
        chk("midrst_valid", longint'(bus.note_valid), 0);
        chk("midrst_period", longint'(bus.period), 0);
        chk("midrst_sb_empty", longint'(sbq.size()), 0);
        model_reset();
        step(2);
        rst = 1'b1;
        step(2);
        play(SC[9], 5, 1'b0);

        // Timeout, then a second timeout from idle.
        silence(TMO + 200);
        silence(TMO + 200);

        // E4 to G4 switch without a silent gap.
        play(SC[4], 6, 1'b0);
        play(SC[7], 6, 1'b0);

        // Glitchy C4 with one outlier period.
        play(SC[0], 6, 1'b1);
        play(1094, 1, 1'b1);
        play(SC[0], 3, 1'b1);
        silence(TMO + 50);

        // Window edges.
        play(SC[9] + 13, 5, 1'b0);
        silence(TMO + 50);
        play(SC[9] - 13, 5, 1'b0);
        silence(TMO + 50);
        play(906, 6, 1'b0);
        play(SC[12], 5, 1'b0);
        silence(TMO + 50);

        // Random notes with jitter, outliers and glitches.
        for (int s = 0; s < 2; s++) begin
            k = $urandom_range(0, 12);
            tol = SC[k] >> TOL;
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    play_period($urandom_range(760, 1480), $urandom_range(0, 2) == 0);
                end else begin
                    play_period(SC[k] + $urandom_range(0, 2 * tol) - tol,
                                $urandom_range(0, 2) == 0);
                end
            end
        end
        silence(TMO + 50);
        step(10);
        chk("sb_drained", longint'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
